fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS datapath. Sits directly upstream of the control unit and decode logic.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched 32-bit instruction, its PC and PC+4 to downstream with a valid/ready handshake. PC+4 is the return address for jal.
- Accepts branch/jump redirects from downstream and discards any in-flight wrong-path fetch.

---
 rtl/mips_pkg.sv | 16 +
 rtl/npc_calc.sv | 24 ++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch datapath: word width, reset defaults
// and the fetch state encoding.
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP_INSTR_C      = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Redirect target calculation for taken branches and j/jal.
// Purely combinational; a jump wins when both redirect pulses coincide.
module npc_calc
    import mips_pkg::*;
(
    input  logic              redir_branch_i,
    input  logic              redir_jump_i,
    input  logic [WORD_W-1:0] redir_pc4_i,
    input  logic [15:0]       redir_imm16_i,
    input  logic [25:0]       redir_idx26_i,
    output logic [WORD_W-1:0] target_o,
    output logic              redirect_o
);

    logic [WORD_W-1:0] branch_tgt;
    logic [WORD_W-1:0] jump_tgt;

    assign branch_tgt = redir_pc4_i + {{14{redir_imm16_i[15]}}, redir_imm16_i, 2'b00};
    assign jump_tgt   = {redir_pc4_i[31:28], redir_idx26_i, 2'b00};

    assign target_o   = redir_jump_i ? jump_tgt : branch_tgt;
    assign redirect_o = redir_branch_i | redir_jump_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read at a time and holds
// the fetched word for decode until accepted or redirected.
//
// state | meaning
// IDLE  | out of reset, request starts next cycle
// FETCH | correct-path request outstanding
// FLUSH | wrong-path request outstanding, pending target waits for its ack
// HOLD  | instruction valid, waiting for instr_ready
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_pc4,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redir_branch,
    input  logic              redir_jump,
    input  logic [WORD_W-1:0] redir_pc4,
    input  logic [15:0]       redir_imm16,
    input  logic [25:0]       redir_idx26
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pending_q, pending_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
    logic [WORD_W-1:0] instr_pc4_q, instr_pc4_d;
    logic              valid_q, valid_d;

    logic [WORD_W-1:0] target;
    logic              redirect;

    npc_calc u_npc_calc (
        .redir_branch_i (redir_branch),
        .redir_jump_i   (redir_jump),
        .redir_pc4_i    (redir_pc4),
        .redir_imm16_i  (redir_imm16),
        .redir_idx26_i  (redir_idx26),
        .target_o       (target),
        .redirect_o     (redirect)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            pending_q   <= '0;
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= RESET_PC;
            instr_pc4_q <= RESET_PC + 32'd4;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            instr_pc4_q <= instr_pc4_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pending_d   = pending_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_pc4_d = instr_pc4_q;
        valid_d     = valid_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) pc_d = target;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        instr_d     = imem_rdata;
                        instr_pc_d  = pc_q;
                        instr_pc4_d = pc_q + 32'd4;
                        valid_d     = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end else if (redirect) begin
                    pending_d = target;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A redirect landing with the ack is newer than pending.
                if (redirect) pending_d = target;
                if (imem_ack) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect || instr_ready) begin
                    pc_d    = redirect ? target : pc_q + 32'd4;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc4   = instr_pc4_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder and
// a scoreboard of expected PCs that are checked as decode accepts them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redir_branch;
    logic        redir_jump;
    logic [31:0] redir_pc4;
    logic [15:0] redir_imm16;
    logic [25:0] redir_idx26;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pc4    (instr_pc4),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redir_branch (redir_branch),
        .redir_jump   (redir_jump),
        .redir_pc4    (redir_pc4),
        .redir_imm16  (redir_imm16),
        .redir_idx26  (redir_idx26)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: acks once the request has waited mem_lat cycles (0 = same cycle).
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every accept, then advance to just after the next edge.
    task automatic tick();
        logic [31:0] e;
        if (instr_valid && instr_ready && !(redir_branch || redir_jump)) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", instr_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("acc_pc",    instr_pc,  e);
                chk("acc_instr", instr,     mem_word(e));
                chk("acc_pc4",   instr_pc4, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redir();
        redir_branch = 1'b0;
        redir_jump   = 1'b0;
        redir_pc4    = '0;
        redir_imm16  = '0;
        redir_idx26  = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        clr_redir();
        @(posedge clk); #1;
        tick();

        // reset state
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,     32'h0);
        chk("rst_pc",    instr_pc,  32'h0);
        chk("rst_pc4",   instr_pc4, 32'h4);

        // zero-wait memory streaming with ready high
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("zw_req",   {31'd0, imem_req},    32'd1);
            chk("zw_addr",  imem_addr,            32'(i * 4));
            chk("zw_vlow",  {31'd0, instr_valid}, 32'd0);
            sb_q.push_back(32'(i * 4));
            tick();
            chk("zw_vhigh", {31'd0, instr_valid}, 32'd1);
            tick();
        end

        // 3-cycle memory, back-pressure in HOLD
        mem_lat     = 3;
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lat_req",   {31'd0, imem_req},    32'd1);
            chk("lat_addr",  imem_addr,            32'h0C);
            chk("lat_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        sb_q.push_back(32'h0C);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_pc",    instr_pc,  32'h0C);
            chk("bp_instr", instr,     mem_word(32'h0C));
            chk("bp_req",   {31'd0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("acc_next_addr", imem_addr, 32'h10);

        // taken branch while holding pc 0x10
        mem_lat     = 0;
        instr_ready = 1'b0;
        tick();
        chk("br_hold_pc", instr_pc, 32'h10);
        redir_branch = 1'b1;
        redir_pc4    = 32'h14;
        redir_imm16  = 16'hFFFE;
        instr_ready  = 1'b1;
        tick();
        clr_redir();
        chk("br_valid", {31'd0, instr_valid}, 32'd0);
        chk("br_nop",   instr,     32'h0);
        chk("br_addr",  imem_addr, 32'h0C);
        sb_q.push_back(32'h0C);
        tick();
        tick();

        // jump while fetch outstanding -> FLUSH
        chk("j_pre_addr", imem_addr, 32'h10);
        mem_lat     = 2;
        redir_jump  = 1'b1;
        redir_pc4   = 32'hA000_0004;
        redir_idx26 = 26'h0000_100;
        tick();
        clr_redir();
        chk("fl_req",   {31'd0, imem_req},    32'd1);
        chk("fl_addr",  imem_addr,            32'h10);
        tick();
        chk("fl_addr2", imem_addr,            32'h10);
        tick();
        chk("fl_valid", {31'd0, instr_valid}, 32'd0);
        chk("fl_new",   imem_addr,            32'hA000_0400);
        mem_lat = 0;
        sb_q.push_back(32'hA000_0400);
        tick();
        tick();

        // branch and jump together with ack: jump wins
        redir_branch = 1'b1;
        redir_jump   = 1'b1;
        redir_pc4    = 32'h1000_0008;
        redir_imm16  = 16'h0004;
        redir_idx26  = 26'h0000_040;
        tick();
        clr_redir();
        chk("both_addr",  imem_addr,            32'h1000_0100);
        chk("both_valid", {31'd0, instr_valid}, 32'd0);
        sb_q.push_back(32'h1000_0100);
        tick();
        tick();

        // two redirects while flushing: later one wins
        mem_lat      = 3;
        redir_branch = 1'b1;
        redir_pc4    = 32'h0000_0200;
        redir_imm16  = 16'h0010;
        tick();
        clr_redir();
        redir_jump   = 1'b1;
        redir_pc4    = 32'h2000_0000;
        redir_idx26  = 26'h0000_080;
        tick();
        clr_redir();
        chk("fl2_addr", imem_addr, 32'h1000_0104);
        tick();
        tick();
        chk("fl2_new",  imem_addr, 32'h2000_0200);
        mem_lat = 0;
        sb_q.push_back(32'h2000_0200);
        tick();
        tick();

        // reset in the middle of a fetch
        mem_lat = 3;
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_req",   {31'd0, imem_req},    32'd0);
        chk("mr_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_pc",    instr_pc,  32'h0);
        chk("mr_pc4",   instr_pc4, 32'h4);
        rst_n   = 1'b1;
        mem_lat = 0;
        tick();
        chk("mr_restart", imem_addr, 32'h0);
        sb_q.push_back(32'h0);
        tick();
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
